// File: rtl/te_pkg.sv
// Shared constants for the instruction trace encoder.
//   BRANCH_MAP_LEN   : number of branch outcomes one branch map can hold
//   BRANCH_COUNT_LEN : width of the counter that indexes the branch map
package te_pkg;

  localparam int unsigned BRANCH_MAP_LEN   = 31;
  localparam int unsigned BRANCH_COUNT_LEN = 5;

endpackage : te_pkg

// File: rtl/te_branch_map.sv
// Branch-map accumulator for the instruction trace encoder.
// Records one bit per retired conditional branch (1 = not taken, 0 = taken),
// packed from bit 0 upward, until the packet emitter consumes the map with flush_i.
//
// Ports:
//   clk_i          : clock, all state changes on the rising edge
//   rst_i          : synchronous active-high reset
//   trace_enable_i : tracing active; while low the map is held cleared
//   valid_i        : a qualified instruction retires this cycle
//   branch_i       : the retiring instruction is a conditional branch
//   branch_taken_i : branch outcome (used only when valid_i & branch_i)
//   flush_i        : emitter consumed map_o/branches_o this cycle
//   map_o          : outcome bits, bit i = branch i
//   branches_o     : number of valid bits in map_o
//   is_full_o      : branches_o == MAP_LEN
//   is_empty_o     : branches_o == 0
//   overflow_o     : one-cycle pulse, a branch was dropped because the map was full
module te_branch_map
  import te_pkg::*;
#(
  parameter int unsigned MAP_LEN   = BRANCH_MAP_LEN,
  parameter int unsigned COUNT_LEN = BRANCH_COUNT_LEN
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 trace_enable_i,
  input  logic                 valid_i,
  input  logic                 branch_i,
  input  logic                 branch_taken_i,
  input  logic                 flush_i,
  output logic [MAP_LEN-1:0]   map_o,
  output logic [COUNT_LEN-1:0] branches_o,
  output logic                 is_full_o,
  output logic                 is_empty_o,
  output logic                 overflow_o
);

  // The counter must be able to represent MAP_LEN itself (the "full" value).
  if (!((2 ** COUNT_LEN) > MAP_LEN)) begin : g_cnt_width_check
    $error("te_branch_map: COUNT_LEN too narrow for MAP_LEN");
  end

  localparam logic [COUNT_LEN-1:0] FULL_CNT = COUNT_LEN'(MAP_LEN);
  localparam logic [COUNT_LEN-1:0] ONE_CNT  = COUNT_LEN'(1);

  logic [MAP_LEN-1:0]   map_q;
  logic [MAP_LEN-1:0]   map_next;
  logic [COUNT_LEN-1:0] cnt_q;
  logic [COUNT_LEN-1:0] cnt_next;
  logic                 ovf_q;
  logic                 ovf_next;
  logic                 rec;
  logic [MAP_LEN-1:0]   wr_sel;

  assign rec = valid_i & branch_i & trace_enable_i;

  always_comb begin
    // One-hot select of the next free slot; nothing selected when full.
    wr_sel = '0;
    for (int i = 0; i < int'(MAP_LEN); i++) begin
      wr_sel[i] = (cnt_q == COUNT_LEN'(i));
    end

    map_next = map_q;
    cnt_next = cnt_q;
    ovf_next = 1'b0;

    if (!trace_enable_i) begin
      map_next = '0;
      cnt_next = '0;
    end else if (flush_i) begin
      // The emitter has taken the old contents, so a concurrent branch starts a fresh map.
      map_next = '0;
      cnt_next = '0;
      if (rec) begin
        map_next[0] = ~branch_taken_i;
        cnt_next    = ONE_CNT;
      end
    end else if (rec) begin
      if (cnt_q != FULL_CNT) begin
        // Bits at/above cnt_q are zero, so OR-ing into the selected slot is a plain write.
        map_next = map_q | (wr_sel & {MAP_LEN{~branch_taken_i}});
        cnt_next = cnt_q + ONE_CNT;
      end else begin
        ovf_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      map_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      map_q <= map_next;
      cnt_q <= cnt_next;
      ovf_q <= ovf_next;
    end
  end

  assign map_o      = map_q;
  assign branches_o = cnt_q;
  assign overflow_o = ovf_q;
  assign is_full_o  = (cnt_q == FULL_CNT);
  assign is_empty_o = (cnt_q == '0);

endmodule : te_branch_map

// File: tb/tb_te_branch_map.sv
module tb_te_branch_map;
  import te_pkg::*;

  localparam int ML = BRANCH_MAP_LEN;
  localparam int CL = BRANCH_COUNT_LEN;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          trace_enable_i = 1'b0;
  logic          valid_i = 1'b0;
  logic          branch_i = 1'b0;
  logic          branch_taken_i = 1'b0;
  logic          flush_i = 1'b0;
  logic [ML-1:0] map_o;
  logic [CL-1:0] branches_o;
  logic          is_full_o;
  logic          is_empty_o;
  logic          overflow_o;

  int checks = 0;
  int errors = 0;

  // Reference model: the map as an ordered list of recorded bits plus the overflow flag.
  bit mq[$];
  bit m_ovf = 1'b0;

  te_branch_map dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .trace_enable_i (trace_enable_i),
    .valid_i        (valid_i),
    .branch_i       (branch_i),
    .branch_taken_i (branch_taken_i),
    .flush_i        (flush_i),
    .map_o          (map_o),
    .branches_o     (branches_o),
    .is_full_o      (is_full_o),
    .is_empty_o     (is_empty_o),
    .overflow_o     (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ML-1:0] model_map();
    logic [ML-1:0] m = '0;
    foreach (mq[i]) m[i] = mq[i];
    return m;
  endfunction

  task automatic model_update(input bit r, input bit en, input bit v, input bit b,
                              input bit t, input bit f);
    bit rec = v & b & en;
    m_ovf = 1'b0;
    if (r || !en) begin
      mq.delete();
    end else if (f) begin
      mq.delete();
      if (rec) mq.push_back(!t);
    end else if (rec) begin
      if (mq.size() < ML) mq.push_back(!t);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".map"},   64'(map_o),      64'(model_map()));
    chk({tag, ".cnt"},   64'(branches_o), 64'(mq.size()));
    chk({tag, ".full"},  64'(is_full_o),  64'(mq.size() == ML));
    chk({tag, ".empty"}, 64'(is_empty_o), 64'(mq.size() == 0));
    chk({tag, ".ovf"},   64'(overflow_o), 64'(m_ovf));
  endtask

  // One clock cycle: drive inputs, clock, advance model, compare after the edge.
  task automatic step(input string tag, input bit r, input bit en, input bit v,
                      input bit b, input bit t, input bit f);
    rst_i = r; trace_enable_i = en; valid_i = v; branch_i = b;
    branch_taken_i = t; flush_i = f;
    @(posedge clk_i);
    model_update(r, en, v, b, t, f);
    #1;
    $display("%s rst=%b en=%b v=%b br=%b tk=%b fl=%b -> map=%h cnt=%0d full=%b empty=%b ovf=%b",
             tag, r, en, v, b, t, f, map_o, branches_o, is_full_o, is_empty_o, overflow_o);
    check_all(tag);
  endtask

  initial begin
    // Reset
    step("reset", 1, 0, 0, 0, 0, 0);
    step("reset", 1, 1, 1, 1, 0, 0);
    chk("reset_map",   64'(map_o), 64'd0);
    chk("reset_cnt",   64'(branches_o), 64'd0);
    chk("reset_empty", 64'(is_empty_o), 64'd1);
    chk("reset_full",  64'(is_full_o), 64'd0);

    // Three branches: taken, not-taken, not-taken
    step("br3", 0, 1, 1, 1, 1, 0);
    chk("first_latency_cnt", 64'(branches_o), 64'd1);
    step("br3", 0, 1, 1, 1, 0, 0);
    step("br3", 0, 1, 1, 1, 0, 0);
    chk("br3_map",   64'(map_o), 64'b110);
    chk("br3_cnt",   64'(branches_o), 64'd3);
    chk("br3_empty", 64'(is_empty_o), 64'd0);
    step("nonbranch", 0, 1, 1, 0, 0, 0);
    chk("nonbranch_cnt", 64'(branches_o), 64'd3);

    // Fill with 31 taken branches, then overflow
    step("flush", 0, 1, 0, 0, 0, 1);
    for (int i = 0; i < ML; i++) step("fill", 0, 1, 1, 1, 1, 0);
    chk("full_map",  64'(map_o), 64'd0);
    chk("full_cnt",  64'(branches_o), 64'd31);
    chk("full_flag", 64'(is_full_o), 64'd1);
    step("ovf", 0, 1, 1, 1, 0, 0);
    chk("ovf_pulse", 64'(overflow_o), 64'd1);
    chk("ovf_cnt",   64'(branches_o), 64'd31);
    chk("ovf_map",   64'(map_o), 64'd0);
    step("ovf_end", 0, 1, 0, 0, 0, 0);
    chk("ovf_one_cycle", 64'(overflow_o), 64'd0);

    // Full map: flush with a not-taken branch
    step("flush_rec", 0, 1, 1, 1, 0, 1);
    chk("flush_rec_map", 64'(map_o), 64'd1);
    chk("flush_rec_cnt", 64'(branches_o), 64'd1);
    chk("flush_rec_ovf", 64'(overflow_o), 64'd0);

    // Reach 5, then non-branch retire plus flush
    for (int i = 0; i < 4; i++) step("to5", 0, 1, 1, 1, 0, 0);
    chk("to5_cnt", 64'(branches_o), 64'd5);
    step("nb_flush", 0, 1, 1, 0, 0, 1);
    chk("nb_flush_map",   64'(map_o), 64'd0);
    chk("nb_flush_cnt",   64'(branches_o), 64'd0);
    chk("nb_flush_empty", 64'(is_empty_o), 64'd1);
    step("empty_flush", 0, 1, 0, 0, 0, 1);

    // Seven branches, then drop trace enable while a branch is presented
    for (int i = 0; i < 7; i++) step("to7", 0, 1, 1, 1, 1'($urandom_range(0, 1)), 0);
    chk("to7_cnt", 64'(branches_o), 64'd7);
    step("disable", 0, 0, 1, 1, 0, 0);
    chk("disable_map", 64'(map_o), 64'd0);
    chk("disable_cnt", 64'(branches_o), 64'd0);
    step("reenable", 0, 1, 1, 1, 1, 0);
    chk("reenable_cnt", 64'(branches_o), 64'd1);
    chk("reenable_map", 64'(map_o), 64'd0);

    // Ten branches, then reset together with branch and flush
    for (int i = 0; i < 9; i++) step("to10", 0, 1, 1, 1, 1'($urandom_range(0, 1)), 0);
    chk("to10_cnt", 64'(branches_o), 64'd10);
    step("mid_reset", 1, 1, 1, 1, 0, 1);
    chk("mid_reset_map",   64'(map_o), 64'd0);
    chk("mid_reset_cnt",   64'(branches_o), 64'd0);
    chk("mid_reset_empty", 64'(is_empty_o), 64'd1);
    chk("mid_reset_ovf",   64'(overflow_o), 64'd0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      step("rand",
           $urandom_range(0, 99) == 0,
           $urandom_range(0, 15) != 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 4) < 3,
           1'($urandom_range(0, 1)),
           $urandom_range(0, 39) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_te_branch_map
